// File: rtl/rr_grant_engine_if.sv
// Handshake bundle between the request-capture register, the grant engine and the grant consumers.
// Latency: none, wires only.
// Backpressure: ack releases the current grant; load tells the register when it may capture.
//
// Signals:
//   req         registered request vector, bit i = requester i
//   ack         release from the current grant owner
//   load        capture strobe back to the request register
//   grant       one-hot grant, zero when idle
//   grant_valid high while grant is non-zero
//   grant_id    binary index of the granted bit, zero when idle
//   timeout     one-cycle pulse after a forced release
interface rr_grant_engine_if #(
    parameter int WIDTH = 4,
    parameter int ID_W  = 2
);
    logic [WIDTH-1:0] req;
    logic             ack;
    logic             load;
    logic [WIDTH-1:0] grant;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             timeout;

    // master: the request register / grant owner side
    modport master (
        output req,
        output ack,
        input  load,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    // slave: the grant engine itself
    modport slave (
        input  req,
        input  ack,
        output load,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface

// File: rtl/rr_grant_engine.sv
// Round-robin grant engine: one one-hot grant at a time, priority rotates past each served requester.
// Latency: grant appears one clock after a non-zero req is sampled in IDLE; at least one IDLE cycle between grants.
// Backpressure: a grant is held until ack (or, with RR_TIMEOUT_EN, a forced release after HOLD_MAX cycles).
//
// Ports:
//   clk   single clock, posedge
//   rst   synchronous active-high reset
//   bus   rr_grant_engine_if.slave: req/ack in; load/grant/grant_valid/grant_id/timeout out
//
// Optional feature macro: RR_TIMEOUT_EN (hold counter + forced release + timeout pulse).
module rr_grant_engine #(
    parameter int WIDTH    = 4,
    parameter int ID_W     = 2,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    rr_grant_engine_if.slave  bus
);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("rr_grant_engine: WIDTH must be >= 1");
    end
    if ((2 ** ID_W) < WIDTH) begin : g_bad_idw
        $error("rr_grant_engine: ID_W too narrow for WIDTH");
    end
    if (HOLD_MAX < 2) begin : g_bad_hold
        $error("rr_grant_engine: HOLD_MAX must be >= 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [WIDTH-1:0]   grant_q;
    logic [ID_W-1:0]    gid_q;
    logic               gv_q;
    logic               load_q;

    logic [2*WIDTH-1:0] req2;
    logic [WIDTH-1:0]   rot;
    logic [ID_W-1:0]    pick_off;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W:0]      sum;
    logic               pick_vld;
    logic [ID_W-1:0]    next_ptr;
    logic               release_now;

    // Rotate the request vector so that bit 0 of rot is requester ptr; the
    // lowest set bit of rot is then the first requester at or above ptr.
    assign req2 = {bus.req, bus.req};
    assign rot  = req2[ptr +: WIDTH];

    always_comb begin
        pick_off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pick_off = ID_W'(i);
            end
        end
    end

    assign pick_vld = |bus.req;

    // Undo the rotation: (ptr + offset) mod WIDTH. Both terms are < WIDTH so
    // one conditional subtract is enough.
    assign sum      = {1'b0, ptr} + {1'b0, pick_off};
    assign pick_idx = (sum >= (ID_W+1)'(WIDTH)) ? ID_W'(sum - (ID_W+1)'(WIDTH))
                                                : sum[ID_W-1:0];

    // Served requester becomes lowest priority.
    assign next_ptr = (gid_q == ID_W'(WIDTH - 1)) ? '0 : gid_q + ID_W'(1);

`ifdef RR_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    logic [CNT_W-1:0] hold_cnt;
    logic             timeout_q;
    logic             expire;

    // Counter equals the number of completed GRANT cycles without ack, so the
    // grant is visible for at most HOLD_MAX cycles.
    assign expire      = (hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign release_now = bus.ack || expire;
    assign bus.timeout = timeout_q;
`else
    assign release_now = bus.ack;
    assign bus.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant_q <= '0;
            gid_q   <= '0;
            gv_q    <= 1'b0;
            load_q  <= 1'b1;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef RR_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                    if (pick_vld) begin
                        state   <= GRANT;
                        grant_q <= WIDTH'(1) << pick_idx;
                        gid_q   <= pick_idx;
                        gv_q    <= 1'b1;
                        load_q  <= 1'b0;
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    // req is deliberately ignored here: the grant is held
                    // until released even if the owner's request drops.
                    if (release_now) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        gid_q   <= '0;
                        gv_q    <= 1'b0;
                        load_q  <= 1'b1;
                        ptr     <= next_ptr;
`ifdef RR_TIMEOUT_EN
                        // ack wins over a coincident expiry.
                        timeout_q <= !bus.ack;
`endif
                    end else begin
`ifdef RR_TIMEOUT_EN
                        hold_cnt <= hold_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.load        = load_q;
    assign bus.grant       = grant_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_id    = gid_q;

endmodule

// File: tb/tb_rr_grant_engine.sv
// Self-checking bench for rr_grant_engine: directed vector table, hold/timeout sequences, random vs reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: ack driven by the bench as the grant owner.
module tb_rr_grant_engine;

    localparam int W  = 4;
    localparam int IW = 2;
    localparam int HM = 8;

    logic clk;
    logic rst;

    rr_grant_engine_if #(.WIDTH(W), .ID_W(IW)) bus ();

    rr_grant_engine #(.WIDTH(W), .ID_W(IW), .HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    typedef struct {
        logic          rst;
        logic [W-1:0]  req;
        logic          ack;
        logic [W-1:0]  g;
        logic [IW-1:0] id;
        logic          ld;
    } vec_t;

    vec_t tbl[$];

    task automatic step(input logic r, input logic [W-1:0] rq, input logic a);
        rst     = r;
        bus.req = rq;
        bus.ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] eg, input logic [IW-1:0] eid,
                         input logic el, input logic et);
        logic ev;
        ev = |eg;
        n_vec++;
        if (bus.grant !== eg || bus.grant_valid !== ev || bus.grant_id !== eid ||
            bus.load !== el || bus.timeout !== et) begin
            n_bad++;
            $display("FAIL %s: got grant=%b valid=%b id=%0d load=%b timeout=%b, want grant=%b valid=%b id=%0d load=%b timeout=%b",
                     name, bus.grant, bus.grant_valid, bus.grant_id, bus.load, bus.timeout,
                     eg, ev, eid, el, et);
        end
    endtask

    // Reference model: abstract round-robin rules with modular arithmetic.
    logic m_busy;
    int   m_ptr;
    int   m_owner;
    int   m_held;
    logic m_to;

    task automatic model_step(input logic r, input logic [W-1:0] rq, input logic a);
        bit timeout_on;
`ifdef RR_TIMEOUT_EN
        timeout_on = 1'b1;
`else
        timeout_on = 1'b0;
`endif
        if (r) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; m_held = 0; m_to = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (!m_busy && rq[(m_ptr + i) % W]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + i) % W;
                    m_held  = 1;
                end
            end
        end else begin
            // m_held = cycles the grant has already been visible
            if (a || (timeout_on && m_held >= HM)) begin
                m_to   = !a;
                m_ptr  = (m_owner + 1) % W;
                m_busy = 1'b0;
            end else begin
                m_held++;
            end
        end
    endtask

    initial begin
        logic [W-1:0]  eg;
        logic [IW-1:0] eid;
        logic          r;
        logic [W-1:0]  rq;
        logic          a;

        n_vec   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.ack = 1'b0;

        // rst, req, ack -> grant, id, load   (state after the edge)
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        // single request, release to ptr=3, re-request
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1});
        // reset back to ptr=0, then rotation with all requesting
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b1});
        // wrap: ptr=0 after bit 3, skip to bit 1; then ptr=2 wraps to bit 0
        tbl.push_back('{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'b0011, 1'b1, 4'b0000, 2'd0, 1'b1});
        // hold: grant 0010 stays while req changes and ack is low
        tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0});
        for (int i = 0; i < 6; i++)
            tbl.push_back('{1'b0, 4'b1101, 1'b0, 4'b0010, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1});
        // ack in IDLE has no effect
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1});
        // ptr=2 -> grant bit 2, then reset mid-grant drops it and ptr=0
        tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0});
        tbl.push_back('{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].ack);
            check($sformatf("vec%0d", i), tbl[i].g, tbl[i].id, tbl[i].ld, 1'b0);
        end

        // Long hold / forced release, starting from ptr=0 IDLE.
        step(1'b0, 4'b0001, 1'b0);
        check("hold_start", 4'b0001, 2'd0, 1'b0, 1'b0);
`ifdef RR_TIMEOUT_EN
        for (int i = 0; i < HM - 1; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            check($sformatf("to_hold%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
        end
        step(1'b0, 4'b0001, 1'b0);
        check("to_release", 4'b0000, 2'd0, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 1'b0);
        check("to_pulse_end", 4'b0000, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'b0011, 1'b0);
        check("to_ptr1", 4'b0010, 2'd1, 1'b0, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        check("to_ptr1_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
        // ptr=2: bit 0 found after wrap; ack coincides with expiry
        step(1'b0, 4'b0001, 1'b0);
        check("ackexp_start", 4'b0001, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < HM - 1; i++) begin
            step(1'b0, 4'b0000, 1'b0);
            check($sformatf("ackexp_hold%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
        end
        step(1'b0, 4'b0000, 1'b1);
        check("ackexp_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b0001, 1'b0);
            check($sformatf("hold20_%0d", i), 4'b0001, 2'd0, 1'b0, 1'b0);
        end
        step(1'b0, 4'b0000, 1'b1);
        check("hold20_rel", 4'b0000, 2'd0, 1'b1, 1'b0);
`endif

        // Random traffic against the reference model.
        model_step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        check("rand_rst", 4'b0000, 2'd0, 1'b1, 1'b0);
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            rq = W'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            a  = ($urandom_range(0, 2) == 0);
            model_step(r, rq, a);
            step(r, rq, a);
            eg  = m_busy ? (W'(1) << m_owner) : '0;
            eid = m_busy ? IW'(m_owner) : '0;
            check($sformatf("rand%0d", c), eg, eid, !m_busy, m_to);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
